// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: ID/EX status
// coming in, stall/bubble/flush/hold controls going out.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       jmp;
    logic       mem_busy;
    logic       pc_stall;
    logic       id_bubble;
    logic       if_flush;
    logic       ex_hold;

    // Pipeline side: supplies stage status, consumes controls
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_rd, ex_mem_read, jmp, mem_busy,
        input  pc_stall, id_bubble, if_flush, ex_hold
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_rd, ex_mem_read, jmp, mem_busy,
        output pc_stall, id_bubble, if_flush, ex_hold
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
// Controls are combinational from the current state and inputs.
// Stall and redirect counters saturate, and perf_clr takes priority.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     pipe,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Extra flush cycles owed after the redirect cycle itself
    localparam logic [2:0]       FC_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       fc_q, fc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    logic hz;
    logic pc_stall_c, id_bubble_c, if_flush_c, ex_hold_c;
    logic redirect_inc;

    // Load-use: a load in EX writes a register the ID instruction reads
    assign hz = pipe.id_valid & pipe.ex_valid & pipe.ex_mem_read &
                (pipe.ex_rd != 5'd0) &
                ((pipe.id_uses_rs1 & (pipe.id_rs1 == pipe.ex_rd)) |
                 (pipe.id_uses_rs2 & (pipe.id_rs2 == pipe.ex_rd)));

    // Next-state and raw control decode; priority mem_busy > jmp > hz
    always_comb begin
        state_d      = state_q;
        fc_d         = fc_q;
        pc_stall_c   = 1'b0;
        id_bubble_c  = 1'b0;
        if_flush_c   = 1'b0;
        ex_hold_c    = 1'b0;
        redirect_inc = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                if_flush_c = 1'b1;
                if (pipe.mem_busy) begin
                    // Memory stalls the back end; keep flushing, freeze fc
                    ex_hold_c  = 1'b1;
                    pc_stall_c = 1'b1;
                end else begin
                    id_bubble_c = 1'b1;
                    if (pipe.jmp) begin
                        // Should not happen with a bubble in EX, but honour it
                        redirect_inc = 1'b1;
                        fc_d         = FC_LOAD;
                        state_d      = (FC_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
                    end else begin
                        fc_d = fc_q - 3'd1;
                        if (fc_q <= 3'd1) begin
                            fc_d    = 3'd0;
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            default: begin
                // RUN, and MEM_WAIT falls through here once memory is ready
                if (pipe.mem_busy) begin
                    ex_hold_c  = 1'b1;
                    pc_stall_c = 1'b1;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (pipe.jmp) begin
                        if_flush_c   = 1'b1;
                        id_bubble_c  = 1'b1;
                        redirect_inc = 1'b1;
                        fc_d         = FC_LOAD;
                        state_d      = (FC_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
                    end else if (hz) begin
                        pc_stall_c  = 1'b1;
                        id_bubble_c = 1'b1;
                    end
                end
            end
        endcase
    end

    // While reset is low every control is forced inactive
    assign pipe.ex_hold   = reset & ex_hold_c;
    assign pipe.pc_stall  = reset & pc_stall_c;
    assign pipe.if_flush  = reset & if_flush_c;
    assign pipe.id_bubble = reset & id_bubble_c & ~ex_hold_c;

    // Stall counter next value: clear wins, otherwise saturating count
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (pipe.pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Redirect counter next value: clear wins, otherwise saturating count
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (perf_clr) begin
            redirect_cnt_d = '0;
        end else if (redirect_inc && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + 1'b1;
        end
    end

    // State, flush counter and performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            fc_q           <= 3'd0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            fc_q           <= fc_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) share one stimulus stream and are checked every
// cycle against a cycle-budget model of the sequencing rules.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       perf_clr;
    logic       id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_mem_read, jmp, mem_busy;

    hazard_ctrl_if if_a ();
    hazard_ctrl_if if_b ();

    assign if_a.id_valid    = id_valid;
    assign if_a.id_rs1      = id_rs1;
    assign if_a.id_rs2      = id_rs2;
    assign if_a.id_uses_rs1 = id_uses_rs1;
    assign if_a.id_uses_rs2 = id_uses_rs2;
    assign if_a.ex_valid    = ex_valid;
    assign if_a.ex_rd       = ex_rd;
    assign if_a.ex_mem_read = ex_mem_read;
    assign if_a.jmp         = jmp;
    assign if_a.mem_busy    = mem_busy;
    assign if_b.id_valid    = id_valid;
    assign if_b.id_rs1      = id_rs1;
    assign if_b.id_rs2      = id_rs2;
    assign if_b.id_uses_rs1 = id_uses_rs1;
    assign if_b.id_uses_rs2 = id_uses_rs2;
    assign if_b.ex_valid    = ex_valid;
    assign if_b.ex_rd       = ex_rd;
    assign if_b.ex_mem_read = ex_mem_read;
    assign if_b.jmp         = jmp;
    assign if_b.mem_busy    = mem_busy;

    logic [15:0] sc_a, rc_a;
    logic [3:0]  sc_b, rc_b;
    logic [1:0]  st_a, st_b;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .pipe(if_a), .perf_clr(perf_clr),
        .stall_cnt(sc_a), .redirect_cnt(rc_a), .state(st_a)
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .pipe(if_b), .perf_clr(perf_clr),
        .stall_cnt(sc_b), .redirect_cnt(rc_b), .state(st_b)
    );

    int total = 0;
    int bad   = 0;

    // Model: flush cycles still owed, whether a memory wait is in progress,
    // and the two event tallies.
    int flush_n [2] = '{2, 3};
    int cnt_max [2] = '{65535, 15};
    int owed    [2];
    bit waiting [2];
    int m_sc    [2];
    int m_rc    [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit load_use();
        return id_valid && ex_valid && ex_mem_read && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; waiting[k] = 0; m_sc[k] = 0; m_rc[k] = 0;
        end
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_mem_read = 0; jmp = 0; mem_busy = 0; perf_clr = 0;
    endtask

    // One clock cycle: inputs are already set; evaluate, check, then advance
    task automatic step(input string tag);
        bit e_stall [2], e_bub [2], e_fl [2], e_hold [2], acc [2];
        int e_st [2], n_owed [2];
        bit n_wait [2];
        logic [31:0] o_stall, o_bub, o_fl, o_hold, o_st, o_sc, o_rc;
        string pfx;
        if (!reset) model_clear();
        for (int k = 0; k < 2; k++) begin
            e_stall[k] = 0; e_bub[k] = 0; e_fl[k] = 0; e_hold[k] = 0; acc[k] = 0;
            n_owed[k] = owed[k]; n_wait[k] = waiting[k];
            e_st[k] = (owed[k] > 0) ? 1 : (waiting[k] ? 2 : 0);
            if (reset) begin
                if (owed[k] > 0) begin
                    e_fl[k] = 1;
                    if (mem_busy) begin
                        e_hold[k] = 1; e_stall[k] = 1;
                    end else begin
                        e_bub[k] = 1;
                        if (jmp) begin
                            acc[k] = 1; n_owed[k] = flush_n[k] - 1;
                        end else begin
                            n_owed[k] = owed[k] - 1;
                        end
                    end
                end else if (mem_busy) begin
                    e_hold[k] = 1; e_stall[k] = 1; n_wait[k] = 1;
                end else begin
                    n_wait[k] = 0;
                    if (jmp) begin
                        e_fl[k] = 1; e_bub[k] = 1; acc[k] = 1; n_owed[k] = flush_n[k] - 1;
                    end else if (load_use()) begin
                        e_stall[k] = 1; e_bub[k] = 1;
                    end
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            pfx = (k == 0) ? {tag, "/A"} : {tag, "/B"};
            o_stall = (k == 0) ? 32'(if_a.pc_stall)  : 32'(if_b.pc_stall);
            o_bub   = (k == 0) ? 32'(if_a.id_bubble) : 32'(if_b.id_bubble);
            o_fl    = (k == 0) ? 32'(if_a.if_flush)  : 32'(if_b.if_flush);
            o_hold  = (k == 0) ? 32'(if_a.ex_hold)   : 32'(if_b.ex_hold);
            o_st    = (k == 0) ? 32'(st_a) : 32'(st_b);
            o_sc    = (k == 0) ? 32'(sc_a) : 32'(sc_b);
            o_rc    = (k == 0) ? 32'(rc_a) : 32'(rc_b);
            chk({pfx, " pc_stall"},     o_stall, 32'(e_stall[k]));
            chk({pfx, " id_bubble"},    o_bub,   32'(e_bub[k]));
            chk({pfx, " if_flush"},     o_fl,    32'(e_fl[k]));
            chk({pfx, " ex_hold"},      o_hold,  32'(e_hold[k]));
            chk({pfx, " state"},        o_st,    32'(e_st[k]));
            chk({pfx, " stall_cnt"},    o_sc,    32'(m_sc[k]));
            chk({pfx, " redirect_cnt"}, o_rc,    32'(m_rc[k]));
            $display("step %s: stall=%0d bub=%0d flush=%0d hold=%0d state=%0d sc=%0d rc=%0d",
                     pfx, o_stall, o_bub, o_fl, o_hold, o_st, o_sc, o_rc);
        end
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                owed[k] = n_owed[k];
                waiting[k] = n_wait[k];
                if (perf_clr) begin
                    m_sc[k] = 0; m_rc[k] = 0;
                end else begin
                    if (e_stall[k] && m_sc[k] < cnt_max[k]) m_sc[k]++;
                    if (acc[k] && m_rc[k] < cnt_max[k]) m_rc[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
        ex_valid = 1; ex_rd = rd; ex_mem_read = 1;
    endtask

    initial begin
        clear_in();
        reset = 0;
        model_clear();
        #1;
        // Reset held low: controls forced off even with jmp/mem_busy/hazard
        jmp = 1; mem_busy = 1; set_load_use(5);
        step("reset_busy");
        mem_busy = 0;
        step("reset_jmp");
        clear_in();
        reset = 1;
        step("idle");

        // Load-use: one stall cycle, then the bubble in EX clears it
        set_load_use(5);
        step("lu_hit");
        ex_valid = 0;
        step("lu_after");
        set_load_use(0);
        id_rs1 = 0;
        step("lu_x0");
        clear_in();

        // Taken jump, two/three flush cycles
        jmp = 1;
        step("jmp");
        jmp = 0;
        for (int i = 0; i < 3; i++) step("jmp_tail");

        // Memory wait with simultaneous jump and hazard, jump taken on release
        set_load_use(5); jmp = 1; mem_busy = 1;
        for (int i = 0; i < 3; i++) step("mem_wait");
        mem_busy = 0;
        step("mem_release");
        clear_in();
        for (int i = 0; i < 3; i++) step("mem_tail");

        // Memory stall in the middle of a flush freezes the flush count
        jmp = 1;
        step("fl_jmp");
        jmp = 0;
        step("fl_run");
        mem_busy = 1;
        step("fl_busy");
        step("fl_busy");
        mem_busy = 0;
        for (int i = 0; i < 4; i++) step("fl_tail");

        // Saturation of the narrow counter, then clear beating an increment
        perf_clr = 1;
        step("clr");
        perf_clr = 0;
        set_load_use(5);
        for (int i = 0; i < 20; i++) step("sat");
        perf_clr = 1;
        step("clr_stall");
        perf_clr = 0;
        clear_in();
        step("after_clr");

        // Reset dropped mid-flush
        jmp = 1;
        step("rst_jmp");
        jmp = 0;
        reset = 0;
        step("rst_mid");
        jmp = 1;
        step("rst_hold");
        jmp = 0;
        reset = 1;
        step("rst_rel");
        step("rst_idle");

        // Random traffic with small register indices to make hazards frequent
        for (int n = 0; n < 400; n++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_uses_rs1 = $urandom_range(0, 1) == 1;
            id_uses_rs2 = $urandom_range(0, 1) == 1;
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_rd       = 5'($urandom_range(0, 3));
            ex_mem_read = $urandom_range(0, 1) == 1;
            jmp         = ($urandom_range(0, 7) == 0);
            mem_busy    = ($urandom_range(0, 5) == 0);
            perf_clr    = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 99) != 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
